register_writeback: RTL and testbench
=====================================

# register_writeback

Writeback stage and integer register file for the RV32I core. It sits directly downstream of the ALU execution units, including the LUI unit. Those units register their result onto the shared `rd_value` bus one clock after their enable and release the bus (high impedance) otherwise. This block tracks which destination register each issued instruction targets, commits the bus value one cycle later, serves the two read ports with forwarding of the in-flight result, and counts retired writebacks.

## Interface
Parameters:
- XLEN, 32, data width of registers and the `rd_value` bus
- REG_COUNT, 32, number of architectural registers; index width is log2(REG_COUNT)

Ports:
- clock  input  1  single clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high reset
- writeback_enable  input  1  asserted by decode in the same cycle as the executing ALU unit's enable
- rd_index  input  5  destination register of the instruction issuing this cycle
- rd_value  input  XLEN  shared ALU result bus, valid the cycle after issue
- rs1_index  input  5  read port 1 address
- rs2_index  input  5  read port 2 address
- rs1_value  output  XLEN  read port 1 data, combinational
- rs2_value  output  XLEN  read port 2 data, combinational
- writeback_pending  output  1  registered: a commit is in flight this cycle
- writeback_count  output  32  registered count of committed writebacks

## Operation
- Issue, cycle N, `writeback_enable`=1: on edge N, `pending_valid`<=1 and `pending_index`<=`rd_index`. If `writeback_enable`=0, `pending_valid`<=0.
- Commit, cycle N+1, `pending_valid`=1:
  - on edge N+1, `regs[pending_index]`<=`rd_value`, unless `pending_index`=0;
  - `writeback_count` increments by 1, including writes to x0.
- Back-to-back issue every cycle is legal. Pending state is overwritten each edge, so there is one commit per cycle and no stall.
- x0: never written; reads of index 0 always return 0, even when forwarding.
- Read port p (rs1/rs2), combinational, priority order:
  1. index=0 -> 0
  2. `pending_valid` and `pending_index`=index -> `rd_value` (forward)
  3. otherwise -> `regs[index]`
- `writeback_count` wraps 0xFFFF_FFFF -> 0 silently.
- Bus while `pending_valid`=0: ignored. Z or X on `rd_value` never reaches the array.
- Simultaneous issue and commit to the same index: the commit of the older instruction happens on edge N+1. The newer instruction's value commits on edge N+2. Forwarding during N+1 returns the older value.

## Timing
- Reset: on an edge with `reset`=1:
  - all `regs`<=0;
  - `pending_valid`<=0, `pending_index`<=0;
  - `writeback_count`<=0;
  - `writeback_pending`=0 from the next cycle.
- Reset has priority over issue and commit. A commit in flight at reset is dropped, with no array write and no count increment.
- Issue-to-architectural-visibility latency:
  - value readable through forwarding in cycle N+1;
  - value readable from the array from cycle N+2.
- `writeback_pending` equals `pending_valid`, registered.
- `rs1_value`/`rs2_value` are purely combinational from indices, pending state, `rd_value` and the array. There is no read latency.

## Structure
- Shared package `rv32i_pkg`: XLEN, REG_COUNT, REG_INDEX_WIDTH=5, ZERO_REG=0, shared with decode and the ALU units.
- Sub-module `register_file_array`:
  - REG_COUNT x XLEN storage;
  - 1 synchronous write port with write-enable, 2 asynchronous read ports;
  - synchronous reset clears all entries;
  - does not special-case x0 (gating is done in this block).
- Top-level holds the pending register, the forwarding muxes, the x0 gating and the counter.

## Test plan
- Reset: preload several registers, assert `reset` one cycle -> all reads 0, `writeback_count`=0, `writeback_pending`=0.
- Basic commit: issue `rd_index`=5, drive `rd_value`=0x1234_5000 next cycle -> `rs1_index`=5 reads 0x1234_5000 in N+1 (forward) and N+2 (array); count=1.
- x0: issue `rd_index`=0, bus 0xDEAD_BEEF -> `rs1_value`/`rs2_value` at index 0 stay 0 in all cycles; count increments to 1.
- Back-to-back: issue x3, x3, x4 on consecutive cycles with bus values 0x1, 0x2, 0x3:
  - x3 reads 0x1 in N+1 and 0x2 in N+2;
  - final x3=0x2, x4=0x3;
  - count=3.
- Idle bus: `writeback_enable`=0 for 10 cycles while `rd_value`=Z/random -> no register changes, count unchanged.
- Reset mid-flight: issue x7 with bus 0xAAAA_AAAA in the cycle `reset`=1 -> x7 reads 0, count=0 after reset.

Source files
------------

// File: rtl/rv32i_pkg.sv
// rv32i_pkg: architectural constants shared by decode, the ALU units and writeback
package rv32i_pkg;
  localparam int XLEN = 32;
  localparam int REG_COUNT = 32;
  localparam int REG_INDEX_WIDTH = 5;
  localparam logic [REG_INDEX_WIDTH-1:0] ZERO_REG = '0;
endpackage

// File: rtl/register_file_array.sv
// register_file_array: plain storage, one synchronous write port, two asynchronous read ports
module register_file_array
  import rv32i_pkg::*;
#(
  parameter int XLEN = rv32i_pkg::XLEN,
  parameter int REG_COUNT = rv32i_pkg::REG_COUNT
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       write_enable,
  input  logic [REG_INDEX_WIDTH-1:0] write_index,
  input  logic [XLEN-1:0]            write_value,
  input  logic [REG_INDEX_WIDTH-1:0] read_index_a,
  input  logic [REG_INDEX_WIDTH-1:0] read_index_b,
  output logic [XLEN-1:0]            read_value_a,
  output logic [XLEN-1:0]            read_value_b
);
  logic [XLEN-1:0] regs [REG_COUNT];
  // clear every entry on reset, otherwise write the addressed entry
  always_ff @(posedge clock) begin
    if (reset)
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    else if (write_enable)
      regs[write_index] <= write_value;
  end
  assign read_value_a = regs[read_index_a];
  assign read_value_b = regs[read_index_b];
endmodule

// File: rtl/register_writeback.sv
// register_writeback: commits the ALU bus one cycle after issue, forwards the in-flight result, counts commits
module register_writeback
  import rv32i_pkg::*;
#(
  parameter int XLEN = rv32i_pkg::XLEN,
  parameter int REG_COUNT = rv32i_pkg::REG_COUNT
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       writeback_enable,
  input  logic [REG_INDEX_WIDTH-1:0] rd_index,
  input  logic [XLEN-1:0]            rd_value,
  input  logic [REG_INDEX_WIDTH-1:0] rs1_index,
  input  logic [REG_INDEX_WIDTH-1:0] rs2_index,
  output logic [XLEN-1:0]            rs1_value,
  output logic [XLEN-1:0]            rs2_value,
  output logic                       writeback_pending,
  output logic [31:0]                writeback_count
);
  logic                       pending_valid;
  logic [REG_INDEX_WIDTH-1:0] pending_index;
  logic [XLEN-1:0]            array_a;
  logic [XLEN-1:0]            array_b;
  logic                       write_enable;
  // x0 is gated here; the bus is only sampled while a commit is in flight
  assign write_enable = pending_valid && pending_index != ZERO_REG;
  register_file_array #(.XLEN(XLEN), .REG_COUNT(REG_COUNT)) u_array (
    .clock       (clock),
    .reset       (reset),
    .write_enable(write_enable),
    .write_index (pending_index),
    .write_value (rd_value),
    .read_index_a(rs1_index),
    .read_index_b(rs2_index),
    .read_value_a(array_a),
    .read_value_b(array_b)
  );
  // track the destination of the issuing instruction and count commits; reset drops any in-flight commit
  always_ff @(posedge clock) begin
    if (reset) begin
      pending_valid   <= 1'b0;
      pending_index   <= '0;
      writeback_count <= '0;
    end else begin
      pending_valid   <= writeback_enable;
      pending_index   <= rd_index;
      writeback_count <= writeback_count + {31'd0, pending_valid};
    end
  end
  assign writeback_pending = pending_valid;
  // read ports: x0 first, then the in-flight bus value, then the array
  always_comb begin
    rs1_value = rs1_index == ZERO_REG ? '0 :
                (pending_valid && pending_index == rs1_index) ? rd_value : array_a;
    rs2_value = rs2_index == ZERO_REG ? '0 :
                (pending_valid && pending_index == rs2_index) ? rd_value : array_b;
  end
endmodule

// File: tb/tb_register_writeback.sv
// tb_register_writeback: directed and random stimulus checked against an architectural register model
module tb_register_writeback;
  logic        clock = 1'b0;
  logic        reset;
  logic        writeback_enable;
  logic [4:0]  rd_index;
  logic [31:0] rd_value;
  logic [4:0]  rs1_index;
  logic [4:0]  rs2_index;
  logic [31:0] rs1_value;
  logic [31:0] rs2_value;
  logic        writeback_pending;
  logic [31:0] writeback_count;
  int errors = 0;
  int checks = 0;
  logic [31:0] m_regs [32];
  bit          m_pend;
  logic [4:0]  m_pidx;
  logic [31:0] m_count;

  register_writeback dut (
    .clock            (clock),
    .reset            (reset),
    .writeback_enable (writeback_enable),
    .rd_index         (rd_index),
    .rd_value         (rd_value),
    .rs1_index        (rs1_index),
    .rs2_index        (rs2_index),
    .rs1_value        (rs1_value),
    .rs2_value        (rs2_value),
    .writeback_pending(writeback_pending),
    .writeback_count  (writeback_count)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] expect_read(input logic [4:0] idx, input logic [31:0] bus);
    if (idx == 0) return 32'd0;
    if (m_pend && m_pidx == idx) return bus;
    return m_regs[idx];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got=%h expected=%h", tag, got, want);
    end
  endtask

  // one clock cycle: drive inputs, check outputs against the model, then advance the model at the edge
  task automatic cycle(input bit r, input bit we, input logic [4:0] idx, input logic [31:0] val,
                       input bit zbus, input logic [4:0] a, input logic [4:0] b);
    reset = r;
    writeback_enable = we;
    rd_index = idx;
    rd_value = zbus ? 32'hzzzz_zzzz : val;
    rs1_index = a;
    rs2_index = b;
    #1;
    check("rs1", rs1_value, expect_read(a, val));
    check("rs2", rs2_value, expect_read(b, val));
    check("pending", {31'd0, writeback_pending}, {31'd0, m_pend});
    check("count", writeback_count, m_count);
    @(posedge clock);
    if (r) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_pend = 0;
      m_pidx = 5'd0;
      m_count = 32'd0;
    end else begin
      if (m_pend) begin
        if (m_pidx != 0) m_regs[m_pidx] = val;
        m_count = m_count + 1;
      end
      m_pend = we;
      m_pidx = idx;
    end
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1;
    writeback_enable = 1'b0;
    rd_index = 5'd0;
    rd_value = 32'd0;
    rs1_index = 5'd0;
    rs2_index = 5'd0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_pend = 0;
    m_pidx = 5'd0;
    m_count = 32'd0;
    // preload x1..x4, then reset and sweep every register
    cycle(0, 1, 5'd1, 32'h0, 0, 5'd1, 5'd2);
    cycle(0, 1, 5'd2, 32'h1111_0001, 0, 5'd1, 5'd2);
    cycle(0, 1, 5'd3, 32'h2222_0002, 0, 5'd2, 5'd3);
    cycle(0, 1, 5'd4, 32'h3333_0003, 0, 5'd3, 5'd4);
    cycle(0, 0, 5'd0, 32'h4444_0004, 0, 5'd4, 5'd1);
    cycle(0, 0, 5'd0, 32'h0, 0, 5'd1, 5'd4);
    cycle(1, 0, 5'd0, 32'h0, 0, 5'd1, 5'd2);
    for (int i = 0; i < 16; i++) cycle(0, 0, 5'd0, 32'h0, 0, 5'(2*i), 5'(2*i+1));
    check("reset_count", writeback_count, 32'd0);
    // basic commit to x5: forwarded in N+1, from the array in N+2
    cycle(0, 1, 5'd5, 32'h0, 0, 5'd5, 5'd0);
    cycle(0, 0, 5'd0, 32'h1234_5000, 0, 5'd5, 5'd5);
    cycle(0, 0, 5'd0, 32'h0, 0, 5'd5, 5'd5);
    check("basic_x5", rs1_value, 32'h1234_5000);
    check("basic_count", writeback_count, 32'd1);
    // x0 write is counted but never visible
    cycle(0, 1, 5'd0, 32'h0, 0, 5'd0, 5'd0);
    cycle(0, 0, 5'd0, 32'hDEAD_BEEF, 0, 5'd0, 5'd0);
    cycle(0, 0, 5'd0, 32'h0, 0, 5'd0, 5'd0);
    check("x0_count", writeback_count, 32'd2);
    // back-to-back x3, x3, x4
    cycle(0, 1, 5'd3, 32'h0, 0, 5'd3, 5'd4);
    cycle(0, 1, 5'd3, 32'h1, 0, 5'd3, 5'd4);
    cycle(0, 1, 5'd4, 32'h2, 0, 5'd3, 5'd4);
    cycle(0, 0, 5'd0, 32'h3, 0, 5'd3, 5'd4);
    cycle(0, 0, 5'd0, 32'h0, 0, 5'd3, 5'd4);
    check("b2b_x3", rs1_value, 32'h2);
    check("b2b_x4", rs2_value, 32'h3);
    check("b2b_count", writeback_count, 32'd5);
    // idle bus: high impedance and random values must be ignored
    for (int i = 0; i < 10; i++)
      cycle(0, 0, 5'($urandom), $urandom, i[0], 5'($urandom), 5'($urandom));
    check("idle_x3", rs1_value === 32'h2 || rs1_index != 3 ? 32'd1 : 32'd0, 32'd1);
    check("idle_count", writeback_count, 32'd5);
    // issue during reset is dropped
    cycle(1, 1, 5'd7, 32'h0, 0, 5'd7, 5'd7);
    cycle(0, 0, 5'd0, 32'hAAAA_AAAA, 0, 5'd7, 5'd7);
    cycle(0, 0, 5'd0, 32'h0, 0, 5'd7, 5'd7);
    check("midflight_x7", rs1_value, 32'd0);
    check("midflight_count", writeback_count, 32'd0);
    // random traffic with occasional reset, biased toward a few hot registers
    for (int i = 0; i < 400; i++) begin
      logic [4:0] ri, a, b;
      ri = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
      a = ($urandom_range(0, 1) == 0) ? m_pidx : 5'($urandom);
      b = ($urandom_range(0, 2) == 0) ? ri : 5'($urandom);
      cycle($urandom_range(0, 60) == 0, $urandom_range(0, 3) != 0, ri, $urandom, 0, a, b);
    end
    cycle(0, 0, 5'd0, $urandom, 0, 5'd1, 5'd2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
